// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, requester
// indices, FSM state type and the winner-selection helper.
package alu_arb_pkg;

    // Opcode encoding presented by each requester
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_AND = 1'b1;

    // Requester indices (also the bit position in iReq/oGrant/oValid)
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // A lone requester always wins; under contention the priority index wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic prio);
        if (req == 2'b01) begin
            return REQ0;
        end
        if (req == 2'b10) begin
            return REQ1;
        end
        return prio;
    endfunction

endpackage

// File: rtl/alu_arbiter_nibble_alu.sv
// nibble_alu: combinational WIDTH-bit add/AND with carry-out. Carry is only
// meaningful for add; an AND always reports carry 0.
module nibble_alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;

    // Add at WIDTH+1 bits so the top bit is the carry-out; AND bypasses it
    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        if (op_i == OP_AND) begin
            result_o = a_i & b_i;
            carry_o  = 1'b0;
        end else begin
            result_o = sum[WIDTH-1:0];
            carry_o  = sum[WIDTH];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one nibble_alu between two requesters.
// Sequence per operation: IDLE (arbitrate, latch) -> EXEC (oGrant pulse,
// ALU result registered) -> DONE (oValid pulse) -> IDLE.
// Handshake: a requester holds iReq[r] and its operands until it sees
// oGrant[r]; operands are latched on that edge and later changes are ignored.
// oValid[r] pulses one cycle with oResult/oCarry, which then hold until the
// next completion. Requests are only looked at in IDLE.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins contention, no round-robin pointer); default is round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [1:0]       iReq,
    input  logic             iOp0,
    input  logic [WIDTH-1:0] iA0,
    input  logic [WIDTH-1:0] iB0,
    input  logic             iOp1,
    input  logic [WIDTH-1:0] iA1,
    input  logic [WIDTH-1:0] iB1,
    output logic [1:0]       oGrant,
    output logic [1:0]       oValid,
    output logic [WIDTH-1:0] oResult,
    output logic             oCarry,
    output logic             oBusy
);

    state_e           state_q, state_d;
    logic             win_q, win_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             prio;
    logic             win;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prio = REQ0;
`else
    logic rr_q, rr_d;
    assign prio = rr_q;
`endif

    // The ALU only ever sees the latched operands, never the live inputs
    nibble_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // Next-state and next-output logic for the arbitration sequence
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        grant_d  = 2'b00;
        valid_d  = 2'b00;
        result_d = result_q;
        carry_d  = carry_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_d     = rr_q;
`endif
        win      = pick_winner(iReq, prio);
        case (state_q)
            IDLE: begin
                if (iReq != 2'b00) begin
                    win_d = win;
                    if (win == REQ1) begin
                        op_d    = iOp1;
                        a_d     = iA1;
                        b_d     = iB1;
                        grant_d = 2'b10;
                    end else begin
                        op_d    = iOp0;
                        a_d     = iA0;
                        b_d     = iB0;
                        grant_d = 2'b01;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                valid_d  = (win_q == REQ1) ? 2'b10 : 2'b01;
                state_d  = DONE;
            end
            DONE: begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                // The other requester gets priority at the next contention
                rr_d = ~win_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight operation
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            win_q    <= REQ0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            grant_q  <= 2'b00;
            valid_q  <= 2'b00;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q     <= REQ0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign oGrant  = grant_q;
    assign oValid  = valid_q;
    assign oResult = result_q;
    assign oCarry  = carry_q;
    assign oBusy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run, all checked
// against a reference model (arithmetic on ints, a priority variable and an
// expected-result queue).
module tb_alu_arbiter;

    localparam int   W     = 4;
    localparam int   EW    = W + 2;
    localparam logic T_ADD = 1'b0;
    localparam logic T_AND = 1'b1;

    // ---------------- clock / reset / DUT ----------------
    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic [1:0]   iReq = 2'b00;
    logic         iOp0 = 1'b0;
    logic [W-1:0] iA0  = '0;
    logic [W-1:0] iB0  = '0;
    logic         iOp1 = 1'b0;
    logic [W-1:0] iA1  = '0;
    logic [W-1:0] iB1  = '0;
    logic [1:0]   oGrant;
    logic [1:0]   oValid;
    logic [W-1:0] oResult;
    logic         oCarry;
    logic         oBusy;

    always #5 iClk = ~iClk;

    alu_arbiter #(.WIDTH(W)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iReq    (iReq),
        .iOp0    (iOp0),
        .iA0     (iA0),
        .iB0     (iB0),
        .iOp1    (iOp1),
        .iA1     (iA1),
        .iB1     (iB1),
        .oGrant  (oGrant),
        .oValid  (oValid),
        .oResult (oResult),
        .oCarry  (oCarry),
        .oBusy   (oBusy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model / scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           model_prio = 0;
    logic [EW-1:0] exp_q[$];

    // {carry, result} from plain integer arithmetic
    function automatic logic [W:0] ref_alu(input logic op, input int a, input int b);
        int s;
        if (op == T_AND) s = a & b;
        else             s = a + b;
        return (W+1)'(s);
    endfunction

    // Who should win: lone requester, otherwise whoever holds priority
    function automatic logic ref_pick(input logic [1:0] req);
        if (req == 2'b01) return 1'b0;
        if (req == 2'b10) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return (model_prio != 0);
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        iReq = 2'b00;
        step();
        step();
        iRst = 1'b0;
        model_prio = 0;
        exp_q.delete();
    endtask

    task automatic set_req0(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        iOp0 = op; iA0 = a; iB0 = b;
    endtask

    task automatic set_req1(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        iOp1 = op; iA1 = a; iB1 = b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (oGrant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b exp 00", oGrant); end
        n_checks++; if (oValid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b exp 00", oValid); end
        n_checks++; if (oResult !== '0) begin n_fail++; $display("FAIL reset_result got %0d exp 0", oResult); end
        n_checks++; if (oCarry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", oCarry); end
        n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", oBusy); end
    endtask

    task automatic test_single(input int r, input logic op, input int a, input int b);
        logic          w;
        logic [1:0]    req;
        logic [1:0]    exp_oh;
        logic [EW-1:0] e;
        if (r == 0) set_req0(op, W'(a), W'(b));
        else        set_req1(op, W'(a), W'(b));
        req  = (r == 0) ? 2'b01 : 2'b10;
        iReq = req;
        w = ref_pick(req);
        exp_q.push_back({w, ref_alu(op, a, b)});
        exp_oh = w ? 2'b10 : 2'b01;
        step();
        n_checks++; if (oGrant !== exp_oh) begin n_fail++; $display("FAIL single_grant r%0d got %b exp %b", r, oGrant, exp_oh); end
        n_checks++; if (oValid !== 2'b00) begin n_fail++; $display("FAIL single_early_valid r%0d got %b exp 00", r, oValid); end
        n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL single_busy1 r%0d got %b exp 1", r, oBusy); end
        iReq = 2'b00;
        step();
        e = exp_q.pop_front();
        exp_oh = e[W+1] ? 2'b10 : 2'b01;
        n_checks++; if (oValid !== exp_oh) begin n_fail++; $display("FAIL single_valid r%0d got %b exp %b", r, oValid, exp_oh); end
        n_checks++; if (oResult !== e[W-1:0]) begin n_fail++; $display("FAIL single_result r%0d got %0d exp %0d", r, oResult, e[W-1:0]); end
        n_checks++; if (oCarry !== e[W]) begin n_fail++; $display("FAIL single_carry r%0d got %b exp %b", r, oCarry, e[W]); end
        n_checks++; if (oGrant !== 2'b00) begin n_fail++; $display("FAIL single_grant_len r%0d got %b exp 00", r, oGrant); end
        n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL single_busy2 r%0d got %b exp 1", r, oBusy); end
        model_prio = w ? 0 : 1;
        step();
        n_checks++; if (oValid !== 2'b00) begin n_fail++; $display("FAIL single_valid_len r%0d got %b exp 00", r, oValid); end
        n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy r%0d got %b exp 0", r, oBusy); end
        n_checks++; if (oResult !== e[W-1:0]) begin n_fail++; $display("FAIL single_hold r%0d got %0d exp %0d", r, oResult, e[W-1:0]); end
    endtask

    task automatic test_contention();
        logic          w;
        logic [1:0]    exp_oh;
        logic [EW-1:0] e;
        do_reset();
        set_req0(T_ADD, 4'd3, 4'd4);
        set_req1(T_AND, 4'hF, 4'd6);
        iReq = 2'b11;
        for (int k = 0; k < 3; k++) begin
            w = ref_pick(2'b11);
            if (w) exp_q.push_back({w, ref_alu(T_AND, 15, 6)});
            else   exp_q.push_back({w, ref_alu(T_ADD, 3, 4)});
            exp_oh = w ? 2'b10 : 2'b01;
            step();
            n_checks++; if (oGrant !== exp_oh) begin n_fail++; $display("FAIL cont_grant k%0d got %b exp %b", k, oGrant, exp_oh); end
            step();
            e = exp_q.pop_front();
            exp_oh = e[W+1] ? 2'b10 : 2'b01;
            n_checks++; if (oValid !== exp_oh) begin n_fail++; $display("FAIL cont_valid k%0d got %b exp %b", k, oValid, exp_oh); end
            n_checks++; if (oResult !== e[W-1:0]) begin n_fail++; $display("FAIL cont_result k%0d got %0d exp %0d", k, oResult, e[W-1:0]); end
            model_prio = w ? 0 : 1;
            step();
            n_checks++; if (oBusy !== 1'b0 || oValid !== 2'b00) begin n_fail++; $display("FAIL cont_idle k%0d got busy %b valid %b exp 0/00", k, oBusy, oValid); end
        end
        iReq = 2'b00;
    endtask

    task automatic test_operand_hold();
        logic [W:0] exp_v;
        set_req0(T_ADD, 4'd5, 4'd7);
        iReq = 2'b01;
        exp_v = ref_alu(T_ADD, 5, 7);
        step();
        n_checks++; if (oGrant !== 2'b01) begin n_fail++; $display("FAIL hold_grant got %b exp 01", oGrant); end
        iA0  = 4'd2;
        iReq = 2'b00;
        step();
        n_checks++; if (oResult !== exp_v[W-1:0]) begin n_fail++; $display("FAIL hold_result got %0d exp %0d", oResult, exp_v[W-1:0]); end
        model_prio = 1;
        step();
    endtask

    task automatic test_reset_mid();
        logic       w;
        logic [1:0] exp_oh;
        logic [W:0] exp_v;
        set_req0(T_ADD, 4'd3, 4'd4);
        set_req1(T_AND, 4'hF, 4'd6);
        iReq = 2'b11;
        w = ref_pick(2'b11);
        exp_oh = w ? 2'b10 : 2'b01;
        step();
        n_checks++; if (oGrant !== exp_oh) begin n_fail++; $display("FAIL rmid_grant got %b exp %b", oGrant, exp_oh); end
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        model_prio = 0;
        n_checks++; if (oValid !== 2'b00) begin n_fail++; $display("FAIL rmid_valid got %b exp 00", oValid); end
        n_checks++; if (oGrant !== 2'b00) begin n_fail++; $display("FAIL rmid_grant0 got %b exp 00", oGrant); end
        n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", oBusy); end
        n_checks++; if (oResult !== '0 || oCarry !== 1'b0) begin n_fail++; $display("FAIL rmid_result got %0d/%b exp 0/0", oResult, oCarry); end
        w = ref_pick(2'b11);
        exp_oh = w ? 2'b10 : 2'b01;
        exp_v  = w ? ref_alu(T_AND, 15, 6) : ref_alu(T_ADD, 3, 4);
        step();
        n_checks++; if (oGrant !== exp_oh) begin n_fail++; $display("FAIL rmid_regrant got %b exp %b", oGrant, exp_oh); end
        iReq = 2'b00;
        step();
        n_checks++; if (oValid !== exp_oh) begin n_fail++; $display("FAIL rmid_valid2 got %b exp %b", oValid, exp_oh); end
        n_checks++; if (oResult !== exp_v[W-1:0]) begin n_fail++; $display("FAIL rmid_result2 got %0d exp %0d", oResult, exp_v[W-1:0]); end
        model_prio = w ? 0 : 1;
        step();
    endtask

    task automatic test_random();
        logic [1:0]    pend;
        logic          pop[2];
        logic [W-1:0]  pa[2];
        logic [W-1:0]  pb[2];
        logic          w;
        logic [1:0]    exp_oh;
        logic [EW-1:0] e;
        logic [W-1:0]  last_res;
        pend = 2'b00;
        last_res = oResult;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
                    pend[r] = 1'b1;
                    pop[r]  = 1'($urandom_range(1, 0));
                    pa[r]   = W'($urandom_range(15, 0));
                    pb[r]   = W'($urandom_range(15, 0));
                end
            end
            iReq = pend;
            set_req0(pop[0], pa[0], pb[0]);
            set_req1(pop[1], pa[1], pb[1]);
            if (pend == 2'b00) begin
                step();
                n_checks++; if (oGrant !== 2'b00 || oBusy !== 1'b0 || oResult !== last_res) begin
                    n_fail++; $display("FAIL rnd_idle it%0d got grant %b busy %b res %0d exp 00/0/%0d", it, oGrant, oBusy, oResult, last_res);
                end
                continue;
            end
            w = ref_pick(pend);
            exp_q.push_back({w, ref_alu(pop[w], int'(pa[w]), int'(pb[w]))});
            exp_oh = w ? 2'b10 : 2'b01;
            step();
            n_checks++; if (oGrant !== exp_oh) begin n_fail++; $display("FAIL rnd_grant it%0d got %b exp %b", it, oGrant, exp_oh); end
            // Winner may move on: new operands now, and maybe a fresh request
            pend[w] = 1'($urandom_range(1, 0));
            pop[w]  = 1'($urandom_range(1, 0));
            pa[w]   = W'($urandom_range(15, 0));
            pb[w]   = W'($urandom_range(15, 0));
            iReq = pend;
            set_req0(pop[0], pa[0], pb[0]);
            set_req1(pop[1], pa[1], pb[1]);
            step();
            e = exp_q.pop_front();
            exp_oh = e[W+1] ? 2'b10 : 2'b01;
            n_checks++; if (oValid !== exp_oh) begin n_fail++; $display("FAIL rnd_valid it%0d got %b exp %b", it, oValid, exp_oh); end
            n_checks++; if ({oCarry, oResult} !== e[W:0]) begin n_fail++; $display("FAIL rnd_result it%0d got %b exp %b", it, {oCarry, oResult}, e[W:0]); end
            last_res = e[W-1:0];
            model_prio = w ? 0 : 1;
            step();
            n_checks++; if (oValid !== 2'b00 || oBusy !== 1'b0) begin n_fail++; $display("FAIL rnd_done it%0d got valid %b busy %b exp 00/0", it, oValid, oBusy); end
        end
        iReq = 2'b00;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single(0, T_ADD, 5, 7);
        test_single(1, T_AND, 5, 10);
        test_single(0, T_ADD, 9, 8);
        test_contention();
        test_operand_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
